// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the miniRV hazard controller: forwarding encodings,
// shadow-stage record and the forwarding priority helper.
package pipe_hazard_ctrl_pkg;

  localparam int unsigned REG_AW = 5;

  localparam int unsigned ST_EX  = 0;
  localparam int unsigned ST_MEM = 1;
  localparam int unsigned ST_WB  = 2;
  localparam int unsigned NUM_ST = 3;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              ld;
  } stage_t;

  // A load in EX has no data yet, so it yields to the older stages.
  function automatic fwd_sel_e pick_fwd(input logic ex_hit, input logic ex_ld,
                                        input logic mem_hit, input logic wb_hit);
    if (ex_hit && !ex_ld) return FWD_EX;
    if (mem_hit)          return FWD_MEM;
    if (wb_hit)           return FWD_WB;
    return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_match.sv
// Compares one shadow stage destination against one ID source operand.
module pipe_hazard_ctrl_hazard_match #(
  parameter int unsigned W = 5
) (
  input  logic         s_valid,
  input  logic         s_we,
  input  logic [W-1:0] s_rd,
  input  logic [W-1:0] rs,
  input  logic         rs_re,
  input  logic         id_valid,
  output logic         hit_c
);

  assign hit_c = s_valid & s_we & (s_rd == rs) & (rs != '0) & rs_re & id_valid;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller for the 5-stage miniRV pipeline: shadow
// scoreboard of EX/MEM/WB destinations, stall/flush/bubble and forwarding.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int unsigned RA_W  = REG_AW,
  parameter int unsigned CNT_W = 32
) (
  input  logic             cpu_clk,
  input  logic             cpu_rst,
  input  logic             id_valid,
  input  logic [RA_W-1:0]  id_rs1,
  input  logic [RA_W-1:0]  id_rs2,
  input  logic             id_rs1_re,
  input  logic             id_rs2_re,
  input  logic [RA_W-1:0]  id_rd,
  input  logic             id_rf_we,
  input  logic             id_is_load,
  input  logic             ex_redirect,
  input  logic             ext_stall,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             stall_all,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  stage_t            shd [NUM_ST];
  logic [REG_AW-1:0] src_rs [2];
  logic              src_re [2];
  logic              hit    [NUM_ST*2];
  logic              load_use;

  assign src_rs[0] = REG_AW'(id_rs1);
  assign src_rs[1] = REG_AW'(id_rs2);
  assign src_re[0] = id_rs1_re;
  assign src_re[1] = id_rs2_re;

  // hit[s*2 + r]: stage s writes source operand r of the ID instruction
  for (genvar s = 0; s < NUM_ST; s++) begin : g_stage
    for (genvar r = 0; r < 2; r++) begin : g_src
      pipe_hazard_ctrl_hazard_match #(.W(REG_AW)) u_match (
        .s_valid  (shd[s].valid),
        .s_we     (shd[s].we),
        .s_rd     (shd[s].rd),
        .rs       (src_rs[r]),
        .rs_re    (src_re[r]),
        .id_valid (id_valid),
        .hit_c    (hit[s*2+r])
      );
    end
  end

  assign load_use = (hit[ST_EX*2] | hit[ST_EX*2+1]) & shd[ST_EX].ld;

  assign fwd_rs1_sel = pick_fwd(hit[ST_EX*2], shd[ST_EX].ld, hit[ST_MEM*2], hit[ST_WB*2]);
  assign fwd_rs2_sel = pick_fwd(hit[ST_EX*2+1], shd[ST_EX].ld, hit[ST_MEM*2+1], hit[ST_WB*2+1]);

  // Pipeline controls, priority ext_stall > ex_redirect > load_use
  always_comb begin
    stall_all    = 1'b0;
    stall_pc     = 1'b0;
    stall_if_id  = 1'b0;
    flush_if_id  = 1'b0;
    bubble_id_ex = 1'b0;
    if (ext_stall) begin
      stall_all   = 1'b1;
      stall_pc    = 1'b1;
      stall_if_id = 1'b1;
    end else if (ex_redirect) begin
      flush_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end else if (load_use) begin
      stall_pc     = 1'b1;
      stall_if_id  = 1'b1;
      bubble_id_ex = 1'b1;
    end
  end

  // Shadow scoreboard advance and performance counters
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      for (int i = 0; i < NUM_ST; i++) shd[i] <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!ext_stall) begin
      shd[ST_WB]  <= shd[ST_MEM];
      shd[ST_MEM] <= shd[ST_EX];
      if (bubble_id_ex) shd[ST_EX] <= '0;
      else shd[ST_EX] <= '{valid: id_valid, rd: REG_AW'(id_rd), we: id_rf_we, ld: id_is_load};
      if (ex_redirect)   flush_cnt <= flush_cnt + CNT_W'(1);
      else if (load_use) stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  assign ex_valid  = shd[ST_EX].valid;
  assign mem_valid = shd[ST_MEM].valid;
  assign wb_valid  = shd[ST_WB].valid;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus
// randomized traffic compared every cycle against a behavioural scoreboard.
module tb_pipe_hazard_ctrl;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        id_valid, id_rs1_re, id_rs2_re, id_rf_we, id_is_load;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_redirect, ext_stall;
  logic        stall_pc, stall_if_id, flush_if_id, bubble_id_ex, stall_all;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic        ex_valid, mem_valid, wb_valid;
  logic [31:0] stall_cnt, flush_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // model: index 0 = EX, 1 = MEM, 2 = WB (oldest)
  bit          m_v [3];
  bit          m_we[3];
  bit          m_ld[3];
  logic [4:0]  m_rd[3];
  int unsigned m_stall = 0;
  int unsigned m_flush = 0;

  always #5 cpu_clk = ~cpu_clk;

  pipe_hazard_ctrl dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_re(id_rs1_re), .id_rs2_re(id_rs2_re),
    .id_rd(id_rd), .id_rf_we(id_rf_we), .id_is_load(id_is_load),
    .ex_redirect(ex_redirect), .ext_stall(ext_stall),
    .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_if_id(flush_if_id),
    .bubble_id_ex(bubble_id_ex), .stall_all(stall_all),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .ex_valid(ex_valid), .mem_valid(mem_valid), .wb_valid(wb_valid),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hit(input int s, input logic [4:0] rs, input logic re);
    return id_valid && re && (rs != 5'd0) && m_v[s] && m_we[s] && (m_rd[s] == rs);
  endfunction

  function automatic logic [1:0] m_sel(input logic [4:0] rs, input logic re);
    if (m_hit(0, rs, re) && !m_ld[0]) return 2'd1;
    if (m_hit(1, rs, re)) return 2'd2;
    if (m_hit(2, rs, re)) return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit m_load_use();
    return m_ld[0] && (m_hit(0, id_rs1, id_rs1_re) || m_hit(0, id_rs2, id_rs2_re));
  endfunction

  // expected controls packed as {stall_all, stall_pc, stall_if_id, flush_if_id, bubble_id_ex}
  function automatic logic [4:0] m_ctrl();
    if (ext_stall)   return 5'b11100;
    if (ex_redirect) return 5'b00011;
    if (m_load_use()) return 5'b01101;
    return 5'b00000;
  endfunction

  // model update on the active edge, using the inputs of the closing cycle
  initial forever begin
    @(posedge cpu_clk);
    if (cpu_rst) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] = 0; m_we[i] = 0; m_ld[i] = 0; m_rd[i] = '0;
      end
      m_stall = 0;
      m_flush = 0;
    end else if (!ext_stall) begin
      bit bub;
      bub = ex_redirect || m_load_use();
      if (ex_redirect) m_flush++;
      else if (bub) m_stall++;
      for (int i = 2; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_we[i] = m_we[i-1]; m_ld[i] = m_ld[i-1]; m_rd[i] = m_rd[i-1];
      end
      m_v[0]  = bub ? 1'b0 : id_valid;
      m_we[0] = bub ? 1'b0 : id_rf_we;
      m_ld[0] = bub ? 1'b0 : id_is_load;
      m_rd[0] = bub ? 5'd0 : id_rd;
    end
  end

  // compare every cycle on the inactive edge
  initial forever begin
    @(negedge cpu_clk);
    if (chk_en) begin
      chk("ctrl", {stall_all, stall_pc, stall_if_id, flush_if_id, bubble_id_ex}, m_ctrl());
      chk("fwd_rs1_sel", fwd_rs1_sel, m_sel(id_rs1, id_rs1_re));
      chk("fwd_rs2_sel", fwd_rs2_sel, m_sel(id_rs2, id_rs2_re));
      chk("valids", {ex_valid, mem_valid, wb_valid}, {m_v[0], m_v[1], m_v[2]});
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
    end
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic inst(input logic v, input logic [4:0] rs1, input logic re1,
                      input logic [4:0] rs2, input logic re2,
                      input logic [4:0] rd, input logic we, input logic ld);
    id_valid = v; id_rs1 = rs1; id_rs1_re = re1; id_rs2 = rs2; id_rs2_re = re2;
    id_rd = rd; id_rf_we = we; id_is_load = ld;
  endtask

  task automatic idle(input int n);
    inst(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 0;
    ext_stall = 0;
    repeat (n) tick();
  endtask

  task automatic mid(); // move to the sampling point of the current cycle
    @(negedge cpu_clk);
    #1;
  endtask

  task automatic rand_cycles(input int n);
    repeat (n) begin
      inst($urandom_range(9, 0) < 8, 5'($urandom_range(3, 0)), 1'($urandom),
           5'($urandom_range(3, 0)), 1'($urandom), 5'($urandom_range(3, 0)),
           $urandom_range(3, 0) != 0, $urandom_range(2, 0) == 0);
      ex_redirect = $urandom_range(9, 0) == 0;
      ext_stall   = $urandom_range(9, 0) == 0;
      tick();
    end
  endtask

  initial begin
    cpu_rst = 1;
    inst(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 0;
    ext_stall = 0;
    tick();
    chk_en = 1;
    tick();
    cpu_rst = 0;
    mid();
    chk("rst_ctrl", {stall_all, stall_pc, stall_if_id, flush_if_id, bubble_id_ex}, 0);
    chk("rst_cnt", {stall_cnt, flush_cnt} == 0, 1);
    chk("rst_valid", {ex_valid, mem_valid, wb_valid}, 0);
    tick();

    // back-to-back ALU: add x5 ; add x6,x5,x5
    inst(1, 1, 1, 2, 1, 5, 1, 0); tick();
    inst(1, 5, 1, 5, 1, 6, 1, 0); mid();
    chk("alu_fwd", {fwd_rs1_sel, fwd_rs2_sel}, 4'b0101);
    chk("alu_nostall", stall_pc, 0);
    tick(); idle(3);

    // load-use: lw x7 ; add x8,x7,x0
    inst(1, 1, 1, 0, 0, 7, 1, 1); tick();
    inst(1, 7, 1, 0, 1, 8, 1, 0); mid();
    chk("lu_ctrl", {stall_pc, stall_if_id, bubble_id_ex}, 3'b111);
    tick(); mid();
    chk("lu_after_stall", stall_pc, 0);
    chk("lu_fwd_mem", fwd_rs1_sel, 2);
    chk("lu_stall_cnt", stall_cnt, 1);
    tick(); idle(3);

    // taken branch
    inst(1, 1, 1, 2, 1, 3, 1, 0); ex_redirect = 1; mid();
    chk("br_ctrl", {flush_if_id, bubble_id_ex, stall_pc}, 3'b110);
    tick(); ex_redirect = 0; inst(0, 0, 0, 0, 0, 0, 0, 0); mid();
    chk("br_flush_cnt", flush_cnt, 1);
    chk("br_ex_valid", ex_valid, 0);
    chk("br_one_cycle", flush_if_id, 0);
    idle(3);

    // lw x0 never stalls or forwards
    inst(1, 1, 1, 0, 0, 0, 1, 1); tick();
    inst(1, 0, 1, 0, 1, 8, 1, 0); mid();
    chk("x0_stall", stall_pc, 0);
    chk("x0_fwd", {fwd_rs1_sel, fwd_rs2_sel}, 0);
    tick(); idle(3);

    // load-use and redirect together: flush only
    inst(1, 1, 1, 0, 0, 7, 1, 1); tick();
    inst(1, 7, 1, 0, 0, 8, 1, 0); ex_redirect = 1; mid();
    chk("prio_ctrl", {stall_pc, flush_if_id, bubble_id_ex}, 3'b011);
    tick(); ex_redirect = 0; mid();
    chk("prio_stall_cnt", stall_cnt, 1);
    chk("prio_flush_cnt", flush_cnt, 2);
    idle(3);

    // ext_stall held 3 cycles over a load-use hazard
    inst(1, 1, 1, 0, 0, 9, 1, 1); tick();
    inst(1, 9, 1, 0, 0, 10, 1, 0); ext_stall = 1;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("xs_ctrl", {stall_all, stall_pc, bubble_id_ex}, 3'b110);
      chk("xs_frozen", {stall_cnt[7:0], ex_valid, mem_valid}, {8'd1, 2'b10});
      tick();
    end
    ext_stall = 0; mid();
    chk("xs_release_lu", {stall_all, stall_pc, bubble_id_ex}, 3'b011);
    tick(); mid();
    chk("xs_fwd_mem", {stall_pc, fwd_rs1_sel}, 3'b010);
    chk("xs_stall_cnt", stall_cnt, 2);
    tick(); idle(3);

    rand_cycles(2000);

    // mid-stream reset
    inst(0, 0, 0, 0, 0, 0, 0, 0); ex_redirect = 0; ext_stall = 0;
    cpu_rst = 1; tick(); tick(); cpu_rst = 0; mid();
    chk("rst2_ctrl", {stall_all, stall_pc, stall_if_id, flush_if_id, bubble_id_ex,
                      fwd_rs1_sel, fwd_rs2_sel}, 0);
    chk("rst2_cnt", {stall_cnt, flush_cnt} == 0, 1);
    chk("rst2_valid", {ex_valid, mem_valid, wb_valid}, 0);
    tick();

    rand_cycles(1500);
    idle(1);
    @(negedge cpu_clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central hazard controller for the 5-stage miniRV pipeline (IF/ID/EX/MEM/WB). It takes ID-stage decode info from the control decoder and keeps its own shadow scoreboard of the EX/MEM/WB destination registers. From that it generates the pipeline stall, flush and bubble controls and the ID-stage operand forwarding selects. It also counts stall and flush events for performance readout.

Parameters:
RA_W, 5, register address width
CNT_W, 32, performance counter width

Ports:
cpu_clk  in  1  system clock
cpu_rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction (have_inst_ID)
id_rs1  in  RA_W  source register 1 of the ID instruction
id_rs2  in  RA_W  source register 2 of the ID instruction
id_rs1_re  in  1  ID instruction reads rs1
id_rs2_re  in  1  ID instruction reads rs2
id_rd  in  RA_W  destination of the ID instruction
id_rf_we  in  1  ID instruction writes the register file
id_is_load  in  1  ID instruction is lb/lbu/lh/lhu/lw
ex_redirect  in  1  EX resolved a taken branch, jal or jalr (npc_op != PC4 and taken)
ext_stall  in  1  global freeze request (memory not ready)
stall_pc  out  1  hold PC
stall_if_id  out  1  hold the IF/ID register
flush_if_id  out  1  clear the IF/ID register to a bubble
bubble_id_ex  out  1  load a bubble into the ID/EX register
stall_all  out  1  freeze every pipeline register (equals ext_stall)
fwd_rs1_sel  out  2  0 = RF, 1 = EX ALU result, 2 = MEM result, 3 = WB data
fwd_rs2_sel  out  2  same encoding for rs2
ex_valid, mem_valid, wb_valid  out  1 each  shadow stage valid bits (trace)
stall_cnt  out  CNT_W  cycles with a load-use stall
flush_cnt  out  CNT_W  ex_redirect events

Behaviour:
- Shadow state: per stage S in {EX, MEM, WB}, registers S_valid, S_rd, S_we, S_ld. Reset clears all of them, and both counters, to 0.
- Hazard matching:
  - A stage "matches" rsN when S_valid & S_we & (S_rd == rsN) & (rsN != 0) & id_rsN_re & id_valid.
  - load_use = (match of rs1 or rs2 in EX) & EX_ld.
- Forwarding select, priority EX > MEM > WB:
  - EX match and !EX_ld -> 1.
  - Else MEM match -> 2.
  - Else WB match -> 3.
  - Else 0.
  - All selects are combinational from the current shadow state and ID inputs, and are 0 whenever id_valid = 0.
- Control outputs (combinational), priority ext_stall > ex_redirect > load_use:
  - ext_stall = 1: stall_all = 1, stall_pc = 1, stall_if_id = 1, all other controls 0. Shadow state and counters hold.
  - ex_redirect = 1: flush_if_id = 1, bubble_id_ex = 1, no stall. Any load_use in the same cycle is ignored because the ID instruction is killed. flush_cnt increments.
  - load_use = 1: stall_pc = 1, stall_if_id = 1, bubble_id_ex = 1. stall_cnt increments. The stall lasts exactly 1 cycle; after it the load sits in MEM and the consumer gets sel = 2.
  - Otherwise all controls are 0.
- Shadow update on each cpu_clk edge (when not ext_stall):
  - WB <= MEM, MEM <= EX.
  - EX <= bubble (valid = 0) if bubble_id_ex, else {id_valid, id_rd, id_rf_we, id_is_load}.
- Counters wrap modulo 2^CNT_W.
- cpu_rst has priority over everything, including mid-stall and mid-flush. After reset, the first cycle's outputs are all 0.
- rd = x0 never creates a hazard or a forward.

Decomposition:
- Shared package/defines header: FWD_RF / FWD_EX / FWD_MEM / FWD_WB encodings, and the shadow-stage record (valid, rd, we, ld).
- Optional sub-module hazard_match: combinational stage-versus-source comparator, instantiated 6 times (3 stages x 2 sources).

Test Plan:
- Reset: assert cpu_rst for 2 cycles mid-stream -> every output and both counters read 0 in the next cycle, and shadow valid bits read 0.
- Back-to-back ALU: add x5 followed by add x6,x5,x5 -> fwd_rs1_sel = fwd_rs2_sel = 1 in the consumer's ID cycle, no stall.
- Load-use: lw x7 followed by add x8,x7,x0 -> 1 cycle of stall_pc/stall_if_id/bubble_id_ex, then fwd_rs1_sel = 2, and stall_cnt = 1.
- Taken branch: ex_redirect pulse -> flush_if_id = bubble_id_ex = 1 for that cycle only, flush_cnt += 1, and the next ex_valid = 0.
- x0 and priority: lw x0 followed by add using x0 -> no stall, sel = 0. Separately, load_use with ex_redirect in the same cycle -> flush only, stall_cnt unchanged.
- ext_stall: hold ext_stall for 3 cycles during a load-use hazard -> stall_all = 1, shadow state and counters frozen; on release, the load-use stall occurs once.
